ptr_auto_load: RTL

- Photoelectric tape reader responder: the tape-side end of the auto-tape-start handshake driven by the turn-on sequencer.
- A rising edge on PWR_AUTO_TAPE_START starts one block read. The block holds WAIT_FOR_TAPE high while it paces 5-bit frames from a tape frame source at reader speed, and drops it when the block's stop code is read.
- Sits between turn_on and the tape image/reader front end; uses the shared timer's tick_ms.

---
 rtl/ptr_auto_load.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ptr_auto_load.sv
// ptr_auto_load -- photoelectric tape reader responder.
//
// Tape-side end of the auto-tape-start handshake. A rising edge on
// PWR_AUTO_TAPE_START (seen while idle or faulted) starts one block read:
// the motor/brake is given START_MS to release, then 5-bit frames are
// requested from the tape frame source at reader speed (one every FRAME_MS)
// until the block's stop code is read. WAIT_FOR_TAPE is high for the whole
// block. A frame request left unanswered for TIMEOUT_MS raises a sticky
// TAPE_FAULT that only a new start edge (or reset) clears.
//
// Optional feature: define PTR_BLOCK_COUNT_EN to add BLOCK_COUNT, a
// saturating count of completed blocks.
//
// Ports:
//   CLOCK               in   system clock
//   rst                 in   synchronous active-high reset
//   tick_ms             in   one-CLOCK pulse every 1 ms
//   PWR_AUTO_TAPE_START in   level from turn_on; rising edge requests a block
//   TAPE_FRAME_REQ      out  request next frame from tape source
//   TAPE_FRAME_VALID    in   qualifies TAPE_FRAME
//   TAPE_FRAME          in   [4:0] frame data
//   RD_STROBE           out  one-cycle pulse, RD_DATA valid
//   RD_DATA             out  [4:0] last captured non-stop frame
//   WAIT_FOR_TAPE       out  high while a block read is in progress
//   BLOCK_DONE          out  one-cycle pulse when the stop code is read
//   TAPE_FAULT          out  sticky frame-request timeout
//   BLOCK_COUNT         out  [7:0] completed blocks (PTR_BLOCK_COUNT_EN only)

module ptr_auto_load #(
  parameter int         START_MS   = 20,
  parameter int         FRAME_MS   = 4,
  parameter int         TIMEOUT_MS = 1000,
  parameter logic [4:0] STOP_CODE  = 5'b10000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       PWR_AUTO_TAPE_START,
  output logic       TAPE_FRAME_REQ,
  input  logic       TAPE_FRAME_VALID,
  input  logic [4:0] TAPE_FRAME,
  output logic       RD_STROBE,
  output logic [4:0] RD_DATA,
  output logic       WAIT_FOR_TAPE,
  output logic       BLOCK_DONE,
`ifdef PTR_BLOCK_COUNT_EN
  output logic [7:0] BLOCK_COUNT,
`endif
  output logic       TAPE_FAULT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPINUP = 3'd1,
    REQ    = 3'd2,
    CHECK  = 3'd3,
    PACE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // A phase ends on the tick that brings its count up to the limit, so
  // compare against limit-1 while that tick is present.
  localparam logic [9:0] START_LAST   = 10'(START_MS - 1);
  localparam logic [9:0] FRAME_LAST   = 10'(FRAME_MS - 1);
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_MS - 1);

  state_t     state_reg, state_next;
  logic [9:0] ms_cnt_reg, ms_cnt_next;
  logic       start_prev_reg;
  logic [4:0] frame_reg;
  logic       rd_strobe_reg;
  logic [4:0] rd_data_reg;
  logic       block_done_reg;
  logic       start_edge;
  logic       is_stop;

  assign start_edge = PWR_AUTO_TAPE_START & ~start_prev_reg;
  assign is_stop    = (frame_reg == STOP_CODE);

  // State register and ms counter
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_reg      <= IDLE;
      ms_cnt_reg     <= '0;
      start_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ms_cnt_reg     <= ms_cnt_next;
      start_prev_reg <= PWR_AUTO_TAPE_START;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FAULT: begin
        if (start_edge) state_next = SPINUP;
      end
      SPINUP: begin
        if (tick_ms && (ms_cnt_reg == START_LAST)) state_next = REQ;
      end
      REQ: begin
        // A frame arriving on the timeout tick still counts.
        if (TAPE_FRAME_VALID) state_next = CHECK;
        else if (tick_ms && (ms_cnt_reg == TIMEOUT_LAST)) state_next = FAULT;
      end
      CHECK: begin
        state_next = is_stop ? IDLE : PACE;
      end
      PACE: begin
        if (tick_ms && (ms_cnt_reg == FRAME_LAST)) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // ms counter restarts on every state change and saturates at all-ones.
  always_comb begin
    ms_cnt_next = ms_cnt_reg;
    if (state_next != state_reg) ms_cnt_next = '0;
    else if (tick_ms && (ms_cnt_reg != '1)) ms_cnt_next = ms_cnt_reg + 10'd1;
  end

  // Level outputs decoded from the state
  always_comb begin
    WAIT_FOR_TAPE  = 1'b0;
    TAPE_FRAME_REQ = 1'b0;
    TAPE_FAULT     = 1'b0;
    case (state_reg)
      SPINUP, CHECK, PACE: WAIT_FOR_TAPE = 1'b1;
      REQ: begin
        WAIT_FOR_TAPE  = 1'b1;
        TAPE_FRAME_REQ = 1'b1;
      end
      FAULT:   TAPE_FAULT = 1'b1;
      default: ;
    endcase
  end

  // Frame capture and the registered pulses leaving CHECK. BLOCK_DONE is
  // registered on the same edge that returns the FSM to IDLE, so it lines
  // up with WAIT_FOR_TAPE falling.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      frame_reg      <= '0;
      rd_strobe_reg  <= 1'b0;
      rd_data_reg    <= '0;
      block_done_reg <= 1'b0;
    end else begin
      if ((state_reg == REQ) && TAPE_FRAME_VALID) frame_reg <= TAPE_FRAME;
      rd_strobe_reg  <= (state_reg == CHECK) && !is_stop;
      block_done_reg <= (state_reg == CHECK) && is_stop;
      if ((state_reg == CHECK) && !is_stop) rd_data_reg <= frame_reg;
    end
  end

  assign RD_STROBE  = rd_strobe_reg;
  assign RD_DATA    = rd_data_reg;
  assign BLOCK_DONE = block_done_reg;

`ifdef PTR_BLOCK_COUNT_EN
  logic [7:0] block_count_reg;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      block_count_reg <= '0;
    end else if ((state_reg == CHECK) && is_stop && (block_count_reg != 8'hFF)) begin
      block_count_reg <= block_count_reg + 8'd1;
    end
  end

  assign BLOCK_COUNT = block_count_reg;
`endif

endmodule
